// File: rtl/vga_pkg.sv
// vga_pkg
// Shared VGA timing definitions: default 640x480@60 timing constants, the
// derived line/frame totals and the coordinate width. Sprite renderers pull
// their screen dimensions from here so they always agree with the timing
// generator.
package vga_pkg;

  // Coordinate width used for counters and DrawX/DrawY.
  localparam int COORD_W = 10;
  // Largest total a COORD_W-bit counter can cover.
  localparam int COORD_SPAN = 32'd1 << COORD_W;

  // Default horizontal timing (pixels).
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;

  // Default vertical timing (lines).
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  // Total length of one axis: visible + front porch + sync + back porch.
  function automatic int span_total(input int visible, input int front,
                                    input int sync, input int back);
    return visible + front + sync + back;
  endfunction

  localparam int H_TOTAL_DEF = span_total(H_VISIBLE_DEF, H_FRONT_DEF,
                                          H_SYNC_DEF, H_BACK_DEF);
  localparam int V_TOTAL_DEF = span_total(V_VISIBLE_DEF, V_FRONT_DEF,
                                          V_SYNC_DEF, V_BACK_DEF);

  // Screen dimensions for renderers.
  localparam int SCREEN_W = H_VISIBLE_DEF;
  localparam int SCREEN_H = V_VISIBLE_DEF;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_wrap_counter.sv
// vga_wrap_counter
// Up-counter over 0..TOP that wraps to 0, with enable and an asynchronous
// active-low reset to PRESET. It exports the value the counter will hold
// after the coming edge (next_count) so a parent can register decoded
// outputs in the same cycle the counter moves.
// Ports:
//   clk        - counting clock
//   rst_n      - asynchronous active-low reset, loads PRESET
//   en         - count enable
//   next_count - value loaded on the next clk edge
//   wrap       - high when enabled and the counter sits at TOP
module vga_wrap_counter
  import vga_pkg::*;
#(
  parameter int WIDTH  = COORD_W,
  parameter int TOP    = 1,
  parameter int PRESET = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] next_count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] TOP_L    = WIDTH'(TOP);
  localparam logic [WIDTH-1:0] PRESET_L = WIDTH'(PRESET);
  localparam logic [WIDTH-1:0] ONE_L    = WIDTH'(32'd1);
  localparam logic [WIDTH-1:0] ZERO_L   = WIDTH'(32'd0);

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] next_s;
  logic             wrap_s;

  // Next-value and wrap computation.
  always_comb begin
    next_s = count_r;
    wrap_s = 1'b0;
    if (en) begin
      if (count_r == TOP_L) begin
        next_s = ZERO_L;
        wrap_s = 1'b1;
      end else begin
        next_s = count_r + ONE_L;
        wrap_s = 1'b0;
      end
    end else begin
      next_s = count_r;
      wrap_s = 1'b0;
    end
  end

  // Counter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= PRESET_L;
    end else begin
      count_r <= next_s;
    end
  end

  assign next_count = next_s;
  assign wrap       = wrap_s;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// VGA raster timing generator. A horizontal and a vertical wrap counter walk
// the full raster; sync, blank and start pulses are decoded from the counters'
// next values and registered, so every output lines up with DrawX/DrawY in
// the same cycle and no port is driven combinationally.
// Ports:
//   vga_clk     - pixel clock, the only clock
//   reset_n     - asynchronous active-low reset (released synchronously upstream)
//   hs, vs      - horizontal / vertical sync, active-low
//   blank       - high on visible pixels (draw enable)
//   DrawX/DrawY - current column / row, tracking the counters everywhere
//   frame_start - one-cycle pulse at pixel (0,0)
//   line_start  - one-cycle pulse at column 0 of every line
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  output logic               hs,
  output logic               vs,
  output logic               blank,
  output logic [COORD_W-1:0] DrawX,
  output logic [COORD_W-1:0] DrawY,
  output logic               frame_start,
  output logic               line_start
);

  localparam int H_TOTAL = span_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = span_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  // Decode thresholds carry one extra bit so a sync window ending exactly at
  // the counter span cannot alias to zero.
  localparam int EXT_W = COORD_W + 1;
  localparam logic [EXT_W-1:0] H_VIS_L    = EXT_W'(H_VISIBLE);
  localparam logic [EXT_W-1:0] HS_START_L = EXT_W'(H_VISIBLE + H_FRONT);
  localparam logic [EXT_W-1:0] HS_END_L   = EXT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [EXT_W-1:0] V_VIS_L    = EXT_W'(V_VISIBLE);
  localparam logic [EXT_W-1:0] VS_START_L = EXT_W'(V_VISIBLE + V_FRONT);
  localparam logic [EXT_W-1:0] VS_END_L   = EXT_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [COORD_W-1:0] COORD_ZERO_L = COORD_W'(32'd0);

  if ((H_TOTAL > COORD_SPAN) || (V_TOTAL > COORD_SPAN)) begin : g_bad_timing
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed the 10-bit coordinate span");
  end

  logic [COORD_W-1:0] hc_next_s;
  logic [COORD_W-1:0] vc_next_s;
  logic               h_wrap_s;
  logic               v_wrap_s;
  logic [EXT_W-1:0]   hc_ext_s;
  logic [EXT_W-1:0]   vc_ext_s;
  logic               hs_next_s;
  logic               vs_next_s;
  logic               blank_next_s;

  logic               hs_r;
  logic               vs_r;
  logic               blank_r;
  logic [COORD_W-1:0] draw_x_r;
  logic [COORD_W-1:0] draw_y_r;
  logic               frame_start_r;
  logic               line_start_r;

  // Both counters preset to their last position so the first edge after
  // reset release wraps them together onto pixel (0,0).
  vga_wrap_counter #(
    .WIDTH  (COORD_W),
    .TOP    (H_TOTAL - 1),
    .PRESET (H_TOTAL - 1)
  ) u_hcount (
    .clk        (vga_clk),
    .rst_n      (reset_n),
    .en         (1'b1),
    .next_count (hc_next_s),
    .wrap       (h_wrap_s)
  );

  vga_wrap_counter #(
    .WIDTH  (COORD_W),
    .TOP    (V_TOTAL - 1),
    .PRESET (V_TOTAL - 1)
  ) u_vcount (
    .clk        (vga_clk),
    .rst_n      (reset_n),
    .en         (h_wrap_s),
    .next_count (vc_next_s),
    .wrap       (v_wrap_s)
  );

  assign hc_ext_s = {1'b0, hc_next_s};
  assign vc_ext_s = {1'b0, vc_next_s};

  // Sync and blank decode of the upcoming counter position.
  always_comb begin
    hs_next_s    = 1'b1;
    vs_next_s    = 1'b1;
    blank_next_s = 1'b0;
    if ((hc_ext_s >= HS_START_L) && (hc_ext_s < HS_END_L)) begin
      hs_next_s = 1'b0;
    end else begin
      hs_next_s = 1'b1;
    end
    if ((vc_ext_s >= VS_START_L) && (vc_ext_s < VS_END_L)) begin
      vs_next_s = 1'b0;
    end else begin
      vs_next_s = 1'b1;
    end
    if ((hc_ext_s < H_VIS_L) && (vc_ext_s < V_VIS_L)) begin
      blank_next_s = 1'b1;
    end else begin
      blank_next_s = 1'b0;
    end
  end

  // Output registers; a wrap of hc means the next column is 0, and a wrap
  // of vc (only possible together with hc) means the next pixel is (0,0).
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_r          <= 1'b1;
      vs_r          <= 1'b1;
      blank_r       <= 1'b0;
      draw_x_r      <= COORD_ZERO_L;
      draw_y_r      <= COORD_ZERO_L;
      frame_start_r <= 1'b0;
      line_start_r  <= 1'b0;
    end else begin
      hs_r          <= hs_next_s;
      vs_r          <= vs_next_s;
      blank_r       <= blank_next_s;
      draw_x_r      <= hc_next_s;
      draw_y_r      <= vc_next_s;
      frame_start_r <= v_wrap_s;
      line_start_r  <= h_wrap_s;
    end
  end

  assign hs          = hs_r;
  assign vs          = vs_r;
  assign blank       = blank_r;
  assign DrawX       = draw_x_r;
  assign DrawY       = draw_y_r;
  assign frame_start = frame_start_r;
  assign line_start  = line_start_r;

endmodule
